// File: rtl/md_scheduler.sv
// md_scheduler -- multiply/divide unit sequencer with architectural HI/LO.
//
// Accepts an E-stage mult/multu/div/divu, holds the unit busy for a fixed
// number of cycles, then writes the 64-bit result into HI/LO.  mthi/mtlo
// write HI/LO directly when the unit is idle.  Produces the D-stage stall
// request for any instruction that touches HI/LO while the unit is in use.
//
// Parameters
//   MULT_CYCLES : busy cycles for mult/multu (1..15)
//   DIV_CYCLES  : busy cycles for div/divu   (1..15)
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous active-low reset
//   md_op_e    in   E-stage op (0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 none)
//   rs_e,rt_e  in   forwarded E-stage operands
//   md_use_d   in   D-stage instruction uses the mult/div unit or HI/LO
//   hi,lo      out  architectural HI/LO registers
//   start      out  combinational: idle and a mult/div op is presented
//   busy       out  registered: an operation is in flight
//   stall_md   out  combinational: D-stage stall request
module md_scheduler #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  md_op_e,
   input  logic [31:0] rs_e,
   input  logic [31:0] rt_e,
   input  logic        md_use_d,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        start,
   output logic        busy,
   output logic        stall_md
);

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        op_signed;

   // Product of the latched operands; sign-extending both to 64 bits gives the
   // signed product, zero-extending gives the unsigned one.
   function automatic logic [63:0] mul_result(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic        sgn);
      logic signed [63:0] ea;
      logic signed [63:0] eb;
      ea = sgn ? $signed({{32{a[31]}}, a}) : $signed({32'd0, a});
      eb = sgn ? $signed({{32{b[31]}}, b}) : $signed({32'd0, b});
      return 64'(ea * eb);
   endfunction

   // Returns {remainder, quotient}.  Signed division is done on magnitudes so
   // 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0, and
   // the quotient truncates toward zero with the remainder taking the
   // dividend's sign.  A zero divisor yields 0 (caller never writes it).
   function automatic logic [63:0] div_result(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic        sgn);
      logic        neg_a;
      logic        neg_b;
      logic [31:0] ma;
      logic [31:0] mb;
      logic [31:0] q;
      logic [31:0] r;
      neg_a = sgn & a[31];
      neg_b = sgn & b[31];
      ma    = neg_a ? (32'd0 - a) : a;
      mb    = neg_b ? (32'd0 - b) : b;
      q     = (mb != 32'd0) ? (ma / mb) : 32'd0;
      r     = (mb != 32'd0) ? (ma % mb) : 32'd0;
      if (neg_a ^ neg_b) q = 32'd0 - q;
      if (neg_a)         r = 32'd0 - r;
      return {r, q};
   endfunction

   assign start    = (state == IDLE) && (md_op_e >= 3'd1) && (md_op_e <= 3'd4);
   assign stall_md = md_use_d & (busy | start);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         hi        <= 32'd0;
         lo        <= 32'd0;
         op_a      <= 32'd0;
         op_b      <= 32'd0;
         op_signed <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               case (md_op_e)
                  3'd1, 3'd2: begin
                     op_a      <= rs_e;
                     op_b      <= rt_e;
                     op_signed <= (md_op_e == 3'd1);
                     cnt       <= 4'(MULT_CYCLES);
                     state     <= MUL;
                     busy      <= 1'b1;
                  end
                  3'd3, 3'd4: begin
                     op_a      <= rs_e;
                     op_b      <= rt_e;
                     op_signed <= (md_op_e == 3'd3);
                     cnt       <= 4'(DIV_CYCLES);
                     state     <= DIV;
                     busy      <= 1'b1;
                  end
                  3'd5:    hi <= rs_e;
                  3'd6:    lo <= rs_e;
                  default: ;
               endcase
            end
            MUL, DIV: begin
               // Inputs are ignored while in flight; only the countdown runs.
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (state == MUL) begin
                     {hi, lo} <= mul_result(op_a, op_b, op_signed);
                  end else if (op_b != 32'd0) begin
                     {hi, lo} <= div_result(op_a, op_b, op_signed);
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md_scheduler.sv
module tb_md_scheduler;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk;
   logic        reset;
   logic [2:0]  md_op_e;
   logic [31:0] rs_e;
   logic [31:0] rt_e;
   logic        md_use_d;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        start;
   logic        busy;
   logic        stall_md;

   int n_tests = 0;
   int n_fail  = 0;

   md_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk      (clk),
      .reset    (reset),
      .md_op_e  (md_op_e),
      .rs_e     (rs_e),
      .rt_e     (rt_e),
      .md_use_d (md_use_d),
      .hi       (hi),
      .lo       (lo),
      .start    (start),
      .busy     (busy),
      .stall_md (stall_md)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Computes the whole result with wide arithmetic when the op is accepted,
   // then counts down the remaining busy cycles and commits at the end.
   function automatic logic [63:0] ref_result(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic signed [63:0] sq;
      logic signed [63:0] sr;
      logic [63:0] ua;
      logic [63:0] ub;
      logic [63:0] res;
      sa = 64'(signed'(a));
      sb = 64'(signed'(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      res = 64'd0;
      case (op)
         3'd1: res = sa * sb;
         3'd2: res = ua * ub;
         3'd3: if (b != 32'd0) begin
            sq  = sa / sb;
            sr  = sa % sb;
            res = {sr[31:0], sq[31:0]};
         end
         3'd4: if (b != 32'd0) res = {32'(ua % ub), 32'(ua / ub)};
         default: res = 64'd0;
      endcase
      return res;
   endfunction

   logic [31:0] m_hi;
   logic [31:0] m_lo;
   logic [63:0] m_res;
   logic        m_wr;
   int          m_left = 0;

   always @(posedge clk) begin
      if (!reset) begin
         m_hi   <= 32'd0;
         m_lo   <= 32'd0;
         m_left <= 0;
         m_wr   <= 1'b0;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         if (m_left == 1 && m_wr) begin
            m_hi <= m_res[63:32];
            m_lo <= m_res[31:0];
         end
      end else begin
         if (md_op_e >= 3'd1 && md_op_e <= 3'd4) begin
            m_res  <= ref_result(md_op_e, rs_e, rt_e);
            m_left <= (md_op_e <= 3'd2) ? MC : DC;
            m_wr   <= !(md_op_e >= 3'd3 && rt_e == 32'd0);
         end else if (md_op_e == 3'd5) begin
            m_hi <= rs_e;
         end else if (md_op_e == 3'd6) begin
            m_lo <= rs_e;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Present one cycle of inputs, then compare every output with the model.
   task automatic cycle(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d, input logic rst_n);
      logic exp_busy;
      logic exp_start;
      @(negedge clk);
      md_op_e  = op;
      rs_e     = a;
      rt_e     = b;
      md_use_d = use_d;
      reset    = rst_n;
      #1;
      exp_busy  = (m_left > 0);
      exp_start = (m_left == 0) && (op >= 3'd1) && (op <= 3'd4);
      check("hi", 64'(hi), 64'(m_hi));
      check("lo", 64'(lo), 64'(m_lo));
      check("busy", 64'(busy), 64'(exp_busy));
      check("start", 64'(start), 64'(exp_start));
      check("stall_md", 64'(stall_md), 64'(use_d & (exp_busy | exp_start)));
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          exp_cycles;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int n_busy;
      logic [31:0] specials [6];
      reset = 1'b0; md_op_e = 3'd0; rs_e = 32'd0; rt_e = 32'd0; md_use_d = 1'b0;

      // reset state
      cycle(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      cycle(3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);

      // table: op, rs, rt, hi, lo, busy cycles (applied in order)
      vecs.push_back('{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, MC});
      vecs.push_back('{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC});
      vecs.push_back('{3'd4, 32'd100,      32'd7,        32'd2,        32'd14,       DC});
      vecs.push_back('{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC});
      vecs.push_back('{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC});
      vecs.push_back('{3'd4, 32'd7,        32'd100,      32'd7,        32'd0,        DC});
      vecs.push_back('{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC});
      vecs.push_back('{3'd5, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 32'h00000000, 0});
      vecs.push_back('{3'd6, 32'h00000022, 32'd0,        32'hDEADBEEF, 32'h00000022, 0});
      vecs.push_back('{3'd5, 32'h00000011, 32'd0,        32'h00000011, 32'h00000022, 0});
      vecs.push_back('{3'd3, 32'h12345678, 32'd0,        32'h00000011, 32'h00000022, DC});

      for (int i = 0; i < vecs.size(); i++) begin
         cycle(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b1);
         if (vecs[i].op == 3'd5 || vecs[i].op == 3'd6)
            check("vec_start_mt", 64'(start), 64'd0);
         n_busy = 0;
         for (int c = 0; c < 20; c++) begin
            cycle(3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
            if (!busy) break;
            n_busy++;
         end
         check($sformatf("vec%0d_cycles", i), 64'(n_busy), 64'(vecs[i].exp_cycles));
         check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
         check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
      end

      // mult with mflo in D throughout; mtlo during busy must be ignored
      cycle(3'd1, 32'd3, 32'd4, 1'b1, 1'b1);
      check("stall_start", 64'(stall_md), 64'd1);
      for (int c = 0; c < MC; c++) begin
         cycle(3'd6, 32'h55, 32'd0, 1'b1, 1'b1);
         check("stall_busy", 64'(stall_md), 64'd1);
      end
      cycle(3'd0, 32'd0, 32'd0, 1'b1, 1'b1);
      check("stall_after", 64'(stall_md), 64'd0);
      check("mtlo_ignored_lo", 64'(lo), 64'd12);
      check("mult_hi", 64'(hi), 64'd0);

      // reset mid-operation aborts multu
      cycle(3'd2, 32'd5, 32'd6, 1'b0, 1'b1);
      cycle(3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      cycle(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      cycle(3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      check("abort_hi", 64'(hi), 64'd0);
      check("abort_lo", 64'(lo), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      for (int c = 0; c < 8; c++) cycle(3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      check("abort_no_write", 64'({hi, lo}), 64'd0);

      // back-to-back: new op in first idle cycle after completion
      cycle(3'd1, 32'd7, 32'd9, 1'b0, 1'b1);
      for (int c = 0; c < MC; c++) cycle(3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      cycle(3'd4, 32'd50, 32'd8, 1'b0, 1'b1);
      check("b2b_start", 64'(start), 64'd1);
      check("b2b_lo_prev", 64'(lo), 64'd63);
      cycle(3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      check("b2b_busy", 64'(busy), 64'd1);
      for (int c = 0; c < DC; c++) cycle(3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      check("b2b_divu", 64'({hi, lo}), {32'd2, 32'd6});

      // randomized traffic against the model
      specials = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFF9};
      for (int i = 0; i < 600; i++) begin
         logic [31:0] a;
         logic [31:0] b;
         a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
         cycle(3'($urandom_range(0, 7)), a, b, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 60) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
